// File: rtl/dwt_tap_feeder.sv
// Tap feeder for the 4-tap DWT combiner. It keeps a replicate-edge delay line per frame and
// presents each odd-sample window twice, first with the low-pass and then with the high-pass coefficients.
module dwt_tap_feeder #(
  parameter int W_IN      = 7,
  parameter int C_IN      = 5,
  parameter int FRAME_LEN = 16,
  parameter int LP0 = -1,
  parameter int LP1 = 3,
  parameter int LP2 = 3,
  parameter int LP3 = -1,
  parameter int HP0 = -1,
  parameter int HP1 = 3,
  parameter int HP2 = -3,
  parameter int HP3 = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_IN-1:0] in_data,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W_IN-1:0] x_c0,
  output logic [W_IN-1:0] x_c1,
  output logic [W_IN-1:0] x_c2,
  output logic [W_IN-1:0] x_c3,
  output logic [C_IN-1:0] c_0,
  output logic [C_IN-1:0] c_1,
  output logic [C_IN-1:0] c_2,
  output logic [C_IN-1:0] c_3,
  output logic            out_band,
  output logic            out_last
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  localparam logic [C_IN-1:0] LP0_V = C_IN'(LP0);
  localparam logic [C_IN-1:0] LP1_V = C_IN'(LP1);
  localparam logic [C_IN-1:0] LP2_V = C_IN'(LP2);
  localparam logic [C_IN-1:0] LP3_V = C_IN'(LP3);
  localparam logic [C_IN-1:0] HP0_V = C_IN'(HP0);
  localparam logic [C_IN-1:0] HP1_V = C_IN'(HP1);
  localparam logic [C_IN-1:0] HP2_V = C_IN'(HP2);
  localparam logic [C_IN-1:0] HP3_V = C_IN'(HP3);

  typedef enum logic {IDLE, RUN} in_state_t;
  typedef enum logic [1:0] {EMPTY, SLOT_L, SLOT_H} slot_t;

  in_state_t       state, state_nxt;
  slot_t           slot, slot_nxt;
  logic [CW-1:0]   cnt;
  logic [W_IN-1:0] d0, d1, d2;
  logic            last_r;

  logic accept, hs, start, shift, snap, frame_end;

  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign start     = accept && in_sof;
  assign shift     = accept && !in_sof && (state == RUN);
  assign snap      = shift && cnt[0];
  assign frame_end = shift && (cnt == CW'(FRAME_LEN - 1));

  // An odd sample may only enter when its window has somewhere to go this edge.
  assign in_ready = (state == IDLE) || !cnt[0] || (slot == EMPTY) ||
                    ((slot == SLOT_H) && out_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      slot  <= EMPTY;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (start)          state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slot_nxt = slot;
    case (slot)
      EMPTY:  if (snap) slot_nxt = SLOT_L;
      SLOT_L: if (hs)   slot_nxt = SLOT_H;
      SLOT_H: if (hs)   slot_nxt = snap ? SLOT_L : EMPTY;
      default: slot_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_band  = 1'b0;
    out_last  = 1'b0;
    c_0 = '0;
    c_1 = '0;
    c_2 = '0;
    c_3 = '0;
    case (slot)
      SLOT_L: begin
        out_valid = 1'b1;
        c_0 = LP0_V;
        c_1 = LP1_V;
        c_2 = LP2_V;
        c_3 = LP3_V;
      end
      SLOT_H: begin
        out_valid = 1'b1;
        out_band  = 1'b1;
        out_last  = last_r;
        c_0 = HP0_V;
        c_1 = HP1_V;
        c_2 = HP2_V;
        c_3 = HP3_V;
      end
      default: ;
    endcase
  end

  // The newest tap comes straight from in_data, so three stored samples cover the window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      d0  <= '0;
      d1  <= '0;
      d2  <= '0;
    end else if (start) begin
      cnt <= CW'(1);
      d0  <= in_data;
      d1  <= in_data;
      d2  <= in_data;
    end else if (shift) begin
      cnt <= frame_end ? '0 : cnt + CW'(1);
      d0  <= in_data;
      d1  <= d0;
      d2  <= d1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_c0   <= '0;
      x_c1   <= '0;
      x_c2   <= '0;
      x_c3   <= '0;
      last_r <= 1'b0;
    end else if (snap) begin
      x_c0   <= in_data;
      x_c1   <= d0;
      x_c2   <= d1;
      x_c3   <= d2;
      last_r <= frame_end;
    end
  end

endmodule

// File: tb/tb_dwt_tap_feeder.sv
// Randomised and directed bench for dwt_tap_feeder. A frame-array/queue model predicts
// every window, coefficient set and handshake-gated in_ready.
module tb_dwt_tap_feeder;

  localparam int W_IN      = 7;
  localparam int C_IN      = 5;
  localparam int FRAME_LEN = 16;
  localparam int LP [4] = '{-1, 3, 3, -1};
  localparam int HP [4] = '{-1, 3, -3, 1};

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [W_IN-1:0] in_data;
  logic            in_sof;
  logic            out_valid;
  logic            out_ready;
  logic [W_IN-1:0] x_c0, x_c1, x_c2, x_c3;
  logic [C_IN-1:0] c_0, c_1, c_2, c_3;
  logic            out_band;
  logic            out_last;

  dwt_tap_feeder #(.W_IN(W_IN), .C_IN(C_IN), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_c0(x_c0), .x_c1(x_c1), .x_c2(x_c2), .x_c3(x_c3),
    .c_0(c_0), .c_1(c_1), .c_2(c_2), .c_3(c_3),
    .out_band(out_band), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int t0, t1, t2, t3;
    bit band;
    bit last;
    int y;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   fx [FRAME_LEN];
  int   idx = 0;
  bit   in_frame = 0;
  int   stall_cycles = 0;
  bit   rand_ready = 0;
  int   y_log[$];
  int   ready_low = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int coef(input bit band, input int i);
    return band ? HP[i] : LP[i];
  endfunction

  function automatic bit model_ready();
    return !in_frame || (idx % 2 == 0) || (q.size() == 0) || (q.size() == 1 && out_ready);
  endfunction

  // Window for odd index n is x[n], x[n-1], x[n-2], x[n-3], clamped at x[0].
  task automatic model_push(input int n);
    int w [4];
    exp_t e;
    for (int i = 0; i < 4; i++) w[i] = fx[(n - i < 0) ? 0 : n - i];
    for (int b = 0; b < 2; b++) begin
      e.t0 = w[0]; e.t1 = w[1]; e.t2 = w[2]; e.t3 = w[3];
      e.band = bit'(b);
      e.last = (b == 1) && (n == FRAME_LEN - 1);
      e.y = 0;
      for (int i = 0; i < 4; i++) e.y += w[i] * coef(bit'(b), i);
      q.push_back(e);
    end
  endtask

  task automatic model_accept(input int d, input bit s);
    if (s) begin
      fx[0] = d;
      idx = 1;
      in_frame = 1;
    end else if (in_frame) begin
      fx[idx] = d;
      if (idx % 2 == 1) model_push(idx);
      idx++;
      if (idx == FRAME_LEN) in_frame = 0;
    end
  endtask

  function automatic int dut_y();
    return int'($signed(x_c0)) * int'($signed(c_0)) + int'($signed(x_c1)) * int'($signed(c_1)) +
           int'($signed(x_c2)) * int'($signed(c_2)) + int'($signed(x_c3)) * int'($signed(c_3));
  endfunction

  task automatic checkOutput();
    exp_t e;
    check("in_ready", in_ready, model_ready());
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      e = q[0];
      check("x_c0", $signed(x_c0), e.t0);
      check("x_c1", $signed(x_c1), e.t1);
      check("x_c2", $signed(x_c2), e.t2);
      check("x_c3", $signed(x_c3), e.t3);
      check("c_0", $signed(c_0), coef(e.band, 0));
      check("c_1", $signed(c_1), coef(e.band, 1));
      check("c_2", $signed(c_2), coef(e.band, 2));
      check("c_3", $signed(c_3), coef(e.band, 3));
      check("out_band", out_band, e.band);
      check("out_last", out_last, e.last);
      check("y", dut_y(), e.y);
    end else begin
      check("c_0_empty", $signed(c_0), 0);
      check("c_3_empty", $signed(c_3), 0);
      check("band_empty", out_band, 0);
      check("last_empty", out_last, 0);
    end
  endtask

  task automatic resetChecks();
    check("rst_out_valid", out_valid, 0);
    check("rst_x_c0", x_c0, 0);
    check("rst_x_c1", x_c1, 0);
    check("rst_x_c2", x_c2, 0);
    check("rst_x_c3", x_c3, 0);
    check("rst_c_0", c_0, 0);
    check("rst_c_2", c_2, 0);
    check("rst_out_band", out_band, 0);
    check("rst_out_last", out_last, 0);
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit s, output bit acc);
    bit hs;
    @(negedge clk);
    in_valid = v;
    in_data  = d[W_IN-1:0];
    in_sof   = s;
    if (stall_cycles > 0) begin
      out_ready = 1'b0;
      stall_cycles--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
    end
    #1;
    checkOutput();
    acc = v && model_ready();
    if (!model_ready()) ready_low++;
    hs = (q.size() != 0) && out_ready;
    if (hs) y_log.push_back(dut_y());
    @(posedge clk);
    if (hs) void'(q.pop_front());
    if (acc) model_accept(d, s);
  endtask

  task automatic send_sample(input int d, input bit s);
    bit acc;
    int n = 0;
    if (rand_ready) repeat ($urandom_range(2)) applyStimulus(0, int'($urandom_range(127)), 0, acc);
    do begin
      applyStimulus(1, d, s, acc);
      n++;
    end while (!acc && n < 100);
    check("accept", acc, 1);
  endtask

  task automatic drain_outputs();
    bit acc;
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      applyStimulus(0, 0, 0, acc);
      n++;
    end
    check("drain", q.size(), 0);
    applyStimulus(0, 0, 0, acc);
  endtask

  task automatic send_counting(input bit stall);
    for (int i = 1; i <= FRAME_LEN; i++) begin
      if (stall && i == 5) stall_cycles = 3;
      send_sample(i, i == 1);
    end
  endtask

  task automatic counting_checks();
    check("count_outputs", y_log.size(), 16);
    if (y_log.size() >= 4) begin
      check("pair0_L", y_log[0], 3);
      check("pair0_H", y_log[1], -1);
      check("pair1_L", y_log[2], 10);
      check("pair1_H", y_log[3], 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n256, n0;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    #3;
    resetChecks();
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] counting frame, continuous");
    y_log.delete(); ready_low = 0;
    send_counting(0);
    drain_outputs();
    counting_checks();
    check("ready_never_low", ready_low, 0);

    $display("[TB] counting frame with stall on pair 1 L");
    y_log.delete(); ready_low = 0;
    send_counting(1);
    drain_outputs();
    counting_checks();
    check("stall_ready_low", ready_low, 3);

    $display("[TB] all -64 frame");
    y_log.delete();
    for (int i = 0; i < FRAME_LEN; i++) send_sample(-64, i == 0);
    drain_outputs();
    n256 = 0; n0 = 0;
    foreach (y_log[i]) begin
      if (y_log[i] == -256) n256++;
      if (y_log[i] == 0) n0++;
    end
    check("neg_L_count", n256, 8);
    check("neg_H_count", n0, 8);

    $display("[TB] samples without sof while idle");
    y_log.delete();
    send_sample(9, 0);
    send_sample(-3, 0);
    check("idle_drop_valid", out_valid, 0);
    for (int i = 0; i < FRAME_LEN; i++) send_sample(3 * i - 20, i == 0);
    drain_outputs();
    check("idle_then_frame", y_log.size(), 16);

    $display("[TB] sof reasserted at index 6");
    y_log.delete();
    for (int i = 0; i < 6; i++) send_sample(10 + i, i == 0);
    for (int i = 0; i < FRAME_LEN; i++) send_sample(-i - 1, i == 0);
    drain_outputs();
    check("restart_outputs", y_log.size(), 22);

    $display("[TB] async reset while L pending");
    send_sample(7, 1);
    stall_cycles = 6;
    send_sample(8, 0);
    #2;
    check("pre_reset_valid", out_valid, q.size() != 0);
    rstn = 1'b0;
    #1;
    resetChecks();
    q.delete();
    in_frame = 0;
    idx = 0;
    stall_cycles = 0;
    @(negedge clk);
    rstn = 1'b1;
    y_log.delete(); ready_low = 0;
    send_counting(0);
    drain_outputs();
    counting_checks();

    $display("[TB] random frames");
    rand_ready = 1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FRAME_LEN; i++)
        send_sample(int'($urandom_range(127)) - 64, (i == 0) || (f == 2 && i == 9));
    end
    drain_outputs();
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
